// File: rtl/router_drain_arb.sv
// Output-side read scheduler for the 1x3 router: grants one destination FIFO
// at a time, round-robin, and drains exactly one whole packet per grant.
module router_drain_arb #(
  parameter int DW   = 8,
  parameter int LENW = DW - 2
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          vld_in_0,
  input  logic          vld_in_1,
  input  logic          vld_in_2,
  input  logic [DW-1:0] dout_0,
  input  logic [DW-1:0] dout_1,
  input  logic [DW-1:0] dout_2,
  input  logic          soft_reset_0,
  input  logic          soft_reset_1,
  input  logic          soft_reset_2,
  input  logic          out_ready,
  output logic          read_enb_0,
  output logic          read_enb_1,
  output logic          read_enb_2,
  output logic [DW-1:0] data_out,
  output logic          data_out_valid,
  output logic [1:0]    grant,
  output logic          pkt_done,
  output logic          pkt_abort
);

  typedef enum logic [2:0] {IDLE, HDR, LEN, BODY, TAIL} state_t;

  localparam logic [1:0]    NO_GRANT = 2'b11;
  localparam logic [LENW:0] REM_ONE  = {{LENW{1'b0}}, 1'b1};

  state_t        state;
  logic [1:0]    last_ptr;
  logic [1:0]    rd_port;
  logic [LENW:0] rem;
  logic [2:0]    vld;
  logic          vld_g;
  logic          srst_g;
  logic          issue;
  logic          found;
  logic [1:0]    pick;
  logic [DW-1:0] rd_data;

  assign vld = {vld_in_2, vld_in_1, vld_in_0};

  function automatic logic [1:0] succ(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vld_g  = 1'b0;
    srst_g = 1'b0;
    case (grant)
      2'd0:    begin vld_g = vld_in_0; srst_g = soft_reset_0; end
      2'd1:    begin vld_g = vld_in_1; srst_g = soft_reset_1; end
      2'd2:    begin vld_g = vld_in_2; srst_g = soft_reset_2; end
      default: ;
    endcase
  end

  // Returned bytes follow the port of the last read, which outlives the grant on an abort.
  always_comb begin
    rd_data = '0;
    case (rd_port)
      2'd0:    rd_data = dout_0;
      2'd1:    rd_data = dout_1;
      2'd2:    rd_data = dout_2;
      default: ;
    endcase
  end

  always_comb begin
    logic [1:0] cand;
    cand  = last_ptr;
    found = 1'b0;
    pick  = NO_GRANT;
    for (int i = 0; i < 3; i++) begin
      cand = succ(cand);
      if (!found && vld[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    issue = 1'b0;
    if (!srst_g) begin
      case (state)
        HDR:     issue = vld_g & out_ready;
        BODY:    issue = vld_g & out_ready & (rem != '0);
        default: ;
      endcase
    end
  end

  assign read_enb_0 = issue && (grant == 2'd0);
  assign read_enb_1 = issue && (grant == 2'd1);
  assign read_enb_2 = issue && (grant == 2'd2);
  assign pkt_done   = (state == TAIL) && !srst_g;
  assign pkt_abort  = (state != IDLE) && srst_g;
  assign data_out   = data_out_valid ? rd_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      grant          <= NO_GRANT;
      last_ptr       <= 2'd2;
      rd_port        <= 2'd0;
      rem            <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= issue;
      if (issue) rd_port <= grant;

      if (state != IDLE && srst_g) begin
        state    <= IDLE;
        grant    <= NO_GRANT;
        last_ptr <= grant;
      end else begin
        case (state)
          IDLE: if (found) begin
            grant <= pick;
            state <= HDR;
          end
          HDR:  if (issue) state <= LEN;
          LEN: begin
            // Payload bytes plus the trailing parity byte.
            rem   <= {1'b0, rd_data[DW-1:2]} + REM_ONE;
            state <= BODY;
          end
          BODY: if (issue) begin
            rem <= rem - REM_ONE;
            if (rem == REM_ONE) state <= TAIL;
          end
          TAIL: begin
            last_ptr <= grant;
            grant    <= NO_GRANT;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_drain_arb.sv
// Directed bench for router_drain_arb: three FIFO models feed the scheduler
// and each scenario task compares outputs cycle by cycle against hand traces.
module tb_router_drain_arb;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_in_0, vld_in_1, vld_in_2;
  logic [7:0] dout_0, dout_1, dout_2;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       out_ready = 1'b1;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [1:0] grant;
  logic       pkt_done, pkt_abort;

  int compared = 0;
  int mismatched = 0;

  router_drain_arb #(.DW(8), .LENW(6)) dut (
    .clock(clock), .resetn(resetn),
    .vld_in_0(vld_in_0), .vld_in_1(vld_in_1), .vld_in_2(vld_in_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .out_ready(out_ready),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out(data_out), .data_out_valid(data_out_valid), .grant(grant),
    .pkt_done(pkt_done), .pkt_abort(pkt_abort)
  );

  always #5 clock = ~clock;

  // FIFO models: read data appears the cycle after the strobe.
  logic [7:0] mem [3][256];
  logic [7:0] rp [3] = '{default: 8'd0};
  logic [7:0] wp [3] = '{default: 8'd0};
  logic [7:0] fdout [3] = '{default: 8'd0};
  logic [2:0] hold = 3'b000;
  logic [2:0] re, vld, gmask;

  assign re       = {read_enb_2, read_enb_1, read_enb_0};
  assign vld      = {vld_in_2, vld_in_1, vld_in_0};
  assign vld_in_0 = (rp[0] != wp[0]) && !hold[0];
  assign vld_in_1 = (rp[1] != wp[1]) && !hold[1];
  assign vld_in_2 = (rp[2] != wp[2]) && !hold[2];
  assign dout_0   = fdout[0];
  assign dout_1   = fdout[1];
  assign dout_2   = fdout[2];
  assign gmask    = (grant == 2'd3) ? 3'b000 : (3'b001 << grant);

  always @(posedge clock) begin
    for (int x = 0; x < 3; x++) begin
      if (re[x]) begin
        fdout[x] <= mem[x][rp[x]];
        rp[x]    <= rp[x] + 8'd1;
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      compared++;
      if (((re & ~(vld & gmask)) != 3'b000) || ($countones(re) > 1)) begin
        mismatched++;
        $display("FAIL read_enb_invariant t=%0t: read_enb=%b vld=%b grant=%0d, want strobe only on valid granted port",
                 $time, re, vld, grant);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int p, input logic [7:0] b);
    mem[p][wp[p]] = b;
    wp[p] = wp[p] + 8'd1;
  endtask

  // Leaves resetn low with the DUT in IDLE and all FIFOs empty.
  task automatic do_reset();
    resetn = 1'b0;
    hold = 3'b111;
    out_ready = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    step();
    for (int x = 0; x < 3; x++) wp[x] = rp[x];
    hold = 3'b000;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    compared += 6;
    if (grant !== 2'd3) begin mismatched++; $display("FAIL reset_grant: got %0d want 3", grant); end
    if (re !== 3'b000) begin mismatched++; $display("FAIL reset_read_enb: got %b want 000", re); end
    if (data_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    if (data_out !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", data_out); end
    if (pkt_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", pkt_done); end
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL reset_abort: got %b want 0", pkt_abort); end
    push(0, 8'h00);
    step();
    compared++;
    if (re !== 3'b000 || grant !== 2'd3) begin
      mismatched++;
      $display("FAIL reset_hold: read_enb=%b grant=%0d want 000/3 while resetn low", re, grant);
    end
  endtask

  task automatic test_single();
    logic [8:0] exp_re   = 9'b001111010;
    logic [8:0] exp_dv   = 9'b011110100;
    logic [8:0] exp_done = 9'b010000000;
    logic [7:0] exp_do [9] = '{8'h00, 8'h00, 8'h0D, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h5A, 8'h00};
    logic [1:0] exp_g;
    do_reset();
    push(1, 8'h0D); push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3); push(1, 8'h5A);
    resetn = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      exp_g = (c == 0 || c == 8) ? 2'd3 : 2'd1;
      compared += 5;
      if (read_enb_1 !== exp_re[c]) begin mismatched++; $display("FAIL single_re1 c%0d: got %b want %b", c, read_enb_1, exp_re[c]); end
      if (data_out_valid !== exp_dv[c]) begin mismatched++; $display("FAIL single_valid c%0d: got %b want %b", c, data_out_valid, exp_dv[c]); end
      if (data_out !== exp_do[c]) begin mismatched++; $display("FAIL single_data c%0d: got %h want %h", c, data_out, exp_do[c]); end
      if (pkt_done !== exp_done[c]) begin mismatched++; $display("FAIL single_done c%0d: got %b want %b", c, pkt_done, exp_done[c]); end
      if (grant !== exp_g) begin mismatched++; $display("FAIL single_grant c%0d: got %0d want %0d", c, grant, exp_g); end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got [$];
    logic [7:0] exp_b;
    logic [1:0] exp_g;
    int dones = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push(p, 8'(4 + p)); push(p, 8'(8'h40 + p)); push(p, 8'(8'h80 + p));
    end
    resetn = 1'b1;
    #1;
    for (int c = 0; c < 19; c++) begin
      exp_g = (c % 6 == 0) ? 2'd3 : 2'(c / 6);
      compared++;
      if (grant !== exp_g) begin mismatched++; $display("FAIL rr_grant c%0d: got %0d want %0d", c, grant, exp_g); end
      if (data_out_valid) got.push_back(data_out);
      if (pkt_done) dones++;
      step();
    end
    compared += 2;
    if (got.size() != 9) begin mismatched++; $display("FAIL rr_bytes: got %0d bytes want 9", got.size()); end
    if (dones != 3) begin mismatched++; $display("FAIL rr_done: got %0d pulses want 3", dones); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      case (i % 3)
        0:       exp_b = 8'(4 + i / 3);
        1:       exp_b = 8'(8'h40 + i / 3);
        default: exp_b = 8'(8'h80 + i / 3);
      endcase
      compared++;
      if (got[i] !== exp_b) begin mismatched++; $display("FAIL rr_byte%0d: got %h want %h", i, got[i], exp_b); end
    end
  endtask

  task automatic test_out_ready_stall();
    logic [14:0] mre = 15'h1C1A;
    logic [14:0] mdv = 15'h3834;
    logic [7:0] exp_do [6] = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int n = 0;
    do_reset();
    push(0, 8'h10); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44); push(0, 8'h55);
    resetn = 1'b1;
    for (int c = 0; c < 15; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      #1;
      compared += 3;
      if (read_enb_0 !== mre[c]) begin mismatched++; $display("FAIL stall_re0 c%0d: got %b want %b", c, read_enb_0, mre[c]); end
      if (data_out_valid !== mdv[c]) begin mismatched++; $display("FAIL stall_valid c%0d: got %b want %b", c, data_out_valid, mdv[c]); end
      if (pkt_done !== (c == 13)) begin mismatched++; $display("FAIL stall_done c%0d: got %b want %b", c, pkt_done, (c == 13)); end
      if (data_out_valid && n < 6) begin
        compared++;
        if (data_out !== exp_do[n]) begin mismatched++; $display("FAIL stall_byte%0d: got %h want %h", n, data_out, exp_do[n]); end
        n++;
      end
      step();
    end
    out_ready = 1'b1;
    compared++;
    if (n != 6) begin mismatched++; $display("FAIL stall_count: got %0d bytes want 6", n); end
  endtask

  task automatic test_vld_drop();
    logic [11:0] mre = 12'h31A;
    logic [11:0] mdv = 12'h634;
    logic [7:0] exp_do [5] = '{8'h0C, 8'h31, 8'h32, 8'h33, 8'h34};
    int n = 0;
    int dones = 0;
    do_reset();
    push(0, 8'h0C); push(0, 8'h31); push(0, 8'h32); push(0, 8'h33); push(0, 8'h34);
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      hold[0] = (c >= 5 && c <= 7);
      #1;
      compared += 2;
      if (read_enb_0 !== mre[c]) begin mismatched++; $display("FAIL drop_re0 c%0d: got %b want %b", c, read_enb_0, mre[c]); end
      if (data_out_valid !== mdv[c]) begin mismatched++; $display("FAIL drop_valid c%0d: got %b want %b", c, data_out_valid, mdv[c]); end
      if (data_out_valid && n < 5) begin
        compared++;
        if (data_out !== exp_do[n]) begin mismatched++; $display("FAIL drop_byte%0d: got %h want %h", n, data_out, exp_do[n]); end
        n++;
      end
      if (pkt_done) begin
        dones++;
        compared++;
        if (c != 10) begin mismatched++; $display("FAIL drop_done_cycle: got c%0d want c10", c); end
      end
      if (c == 11) begin
        compared++;
        if (grant !== 2'd3) begin mismatched++; $display("FAIL drop_idle_grant: got %0d want 3", grant); end
      end
      step();
    end
    hold = 3'b000;
    compared += 2;
    if (dones != 1) begin mismatched++; $display("FAIL drop_done_count: got %0d want 1", dones); end
    if (n != 5) begin mismatched++; $display("FAIL drop_count: got %0d bytes want 5", n); end
  endtask

  task automatic test_soft_abort();
    do_reset();
    push(1, 8'h01); push(1, 8'h77);
    resetn = 1'b1;
    repeat (4) step();
    compared += 2;
    if (pkt_done !== 1'b1) begin mismatched++; $display("FAIL abort_pre_done: got %b want 1", pkt_done); end
    if (data_out !== 8'h77) begin mismatched++; $display("FAIL abort_pre_data: got %h want 77", data_out); end
    push(2, 8'h1A);
    for (int i = 0; i < 6; i++) push(2, 8'(8'h20 + i));
    push(2, 8'h26);
    step();
    step();
    compared++;
    if (grant !== 2'd2) begin mismatched++; $display("FAIL abort_grant2: got %0d want 2", grant); end
    push(0, 8'h00); push(0, 8'h99);
    repeat (4) step();
    soft_reset_2 = 1'b1;
    #1;
    compared += 5;
    if (pkt_abort !== 1'b1) begin mismatched++; $display("FAIL abort_pulse: got %b want 1", pkt_abort); end
    if (read_enb_2 !== 1'b0) begin mismatched++; $display("FAIL abort_no_read: got %b want 0", read_enb_2); end
    if (pkt_done !== 1'b0) begin mismatched++; $display("FAIL abort_no_done: got %b want 0", pkt_done); end
    if (data_out_valid !== 1'b1) begin mismatched++; $display("FAIL abort_pending_valid: got %b want 1", data_out_valid); end
    if (data_out !== 8'h21) begin mismatched++; $display("FAIL abort_pending_data: got %h want 21", data_out); end
    step();
    soft_reset_2 = 1'b0;
    #1;
    compared += 3;
    if (grant !== 2'd3) begin mismatched++; $display("FAIL abort_idle_grant: got %0d want 3", grant); end
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL abort_one_cycle: got %b want 0", pkt_abort); end
    if (data_out_valid !== 1'b0) begin mismatched++; $display("FAIL abort_idle_valid: got %b want 0", data_out_valid); end
    step();
    compared += 2;
    if (grant !== 2'd0) begin mismatched++; $display("FAIL abort_next_grant: got %0d want 0", grant); end
    if (read_enb_0 !== 1'b1) begin mismatched++; $display("FAIL abort_next_read: got %b want 1", read_enb_0); end
  endtask

  task automatic test_max_len();
    logic [7:0] exp_b;
    int reads = 0;
    int n = 0;
    int dones = 0;
    int done_c = -1;
    do_reset();
    push(0, 8'hFC);
    for (int i = 1; i < 64; i++) push(0, 8'(i));
    push(0, 8'hEE);
    resetn = 1'b1;
    #1;
    for (int c = 0; c < 70; c++) begin
      if (read_enb_0) reads++;
      if (data_out_valid) begin
        exp_b = (n == 0) ? 8'hFC : (n == 64) ? 8'hEE : 8'(n);
        compared++;
        if (data_out !== exp_b) begin mismatched++; $display("FAIL maxlen_byte%0d: got %h want %h", n, data_out, exp_b); end
        n++;
      end
      if (pkt_done) begin dones++; done_c = c; end
      if (c == 68) begin
        compared++;
        if (grant !== 2'd3) begin mismatched++; $display("FAIL maxlen_idle_grant: got %0d want 3", grant); end
      end
      step();
    end
    compared += 4;
    if (reads != 65) begin mismatched++; $display("FAIL maxlen_reads: got %0d want 65", reads); end
    if (n != 65) begin mismatched++; $display("FAIL maxlen_count: got %0d bytes want 65", n); end
    if (dones != 1) begin mismatched++; $display("FAIL maxlen_done_count: got %0d want 1", dones); end
    if (done_c != 67) begin mismatched++; $display("FAIL maxlen_done_cycle: got c%0d want c67", done_c); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push(0, 8'hFC);
    for (int i = 1; i < 65; i++) push(0, 8'(i));
    resetn = 1'b1;
    repeat (20) step();
    compared++;
    if (read_enb_0 !== 1'b1) begin mismatched++; $display("FAIL midrst_busy: read_enb_0 got %b want 1", read_enb_0); end
    resetn = 1'b0;
    step();
    compared += 6;
    if (re !== 3'b000) begin mismatched++; $display("FAIL midrst_read_enb: got %b want 000", re); end
    if (data_out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b want 0", data_out_valid); end
    if (data_out !== 8'h00) begin mismatched++; $display("FAIL midrst_data: got %h want 00", data_out); end
    if (pkt_done !== 1'b0) begin mismatched++; $display("FAIL midrst_done: got %b want 0", pkt_done); end
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL midrst_abort: got %b want 0", pkt_abort); end
    if (grant !== 2'd3) begin mismatched++; $display("FAIL midrst_grant: got %0d want 3", grant); end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_out_ready_stall();
    test_vld_drop();
    test_soft_abort();
    test_max_len();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
